// File: rtl/fitness_pkg.sv
// ---------------------------------------------------------------------------
// fitness_pkg
//   Shared definitions for the image fitness evaluator:
//   - FSM state encoding (IDLE / ACCUM / DONE)
//   - count_width(): number of bits needed to hold a count from 0 to
//     max_count inclusive. It sizes the popcount and mismatch counters.
// ---------------------------------------------------------------------------
package fitness_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Guarded so that a degenerate max_count of 0 still yields a 1-bit field.
  function automatic int count_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/row_popcount.sv
// ---------------------------------------------------------------------------
// row_popcount
//   Combinational population count of one image row.
//
// Ports
//   bits   in   Width                 row of pixel-mismatch bits
//   count  out  count_width(Width)    number of set bits in the row
// ---------------------------------------------------------------------------
module row_popcount
  import fitness_pkg::*;
#(
  parameter int Width = 8,
  localparam int CountWidth = count_width(Width)
) (
  input  logic [Width-1:0]      bits,
  output logic [CountWidth-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < Width; i++) begin
      count = count + CountWidth'(bits[i]);
    end
  end

endmodule

// File: rtl/image_fitness_evaluator.sv
// ---------------------------------------------------------------------------
// image_fitness_evaluator
//   Computes the Hamming distance between the morphologic processor's
//   result image and the target image. It handles one row per cycle and
//   reports the result as the individual's fitness. It also keeps a record
//   of the best (lowest) fitness and the id of that individual.
//
// Ports
//   clk           in   1              clock, rising edge
//   rst           in   1              synchronous active-low reset
//   start         in   1              request an evaluation (accepted in IDLE)
//   image         in   W*H            result image, row r at [r*W +: W]
//   target        in   W*H            reference image
//   id            in   IdWidth        individual id, captured with start
//   clear_best    in   1              invalidate the best-so-far record
//   busy          out  1              evaluator not idle
//   done          out  1              one-cycle completion pulse
//   fitness       out  FitnessWidth   mismatch count of last evaluation
//   best_valid    out  1              best record holds a result
//   best_fitness  out  FitnessWidth   lowest fitness since reset/clear
//   best_id       out  IdWidth        id belonging to best_fitness
// ---------------------------------------------------------------------------
module image_fitness_evaluator
  import fitness_pkg::*;
#(
  parameter int ImageWidth  = 8,
  parameter int ImageHeight = 8,
  parameter int IdWidth     = 8,
  localparam int FitnessWidth = count_width(ImageWidth * ImageHeight)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ImageWidth*ImageHeight-1:0] image,
  input  logic [ImageWidth*ImageHeight-1:0] target,
  input  logic [IdWidth-1:0]                id,
  input  logic                              clear_best,
  output logic                              busy,
  output logic                              done,
  output logic [FitnessWidth-1:0]           fitness,
  output logic                              best_valid,
  output logic [FitnessWidth-1:0]           best_fitness,
  output logic [IdWidth-1:0]                best_id
);

  localparam int PixelCount    = ImageWidth * ImageHeight;
  // row_idx must reach ImageHeight itself, so it is sized for 0..ImageHeight.
  localparam int RowIdxWidth   = count_width(ImageHeight);
  localparam int RowCountWidth = count_width(ImageWidth);

  logic [1:0]               state;
  logic [PixelCount-1:0]    diff;
  logic [RowIdxWidth-1:0]   row_idx;
  logic [FitnessWidth-1:0]  acc;
  logic [IdWidth-1:0]       id_reg;
  logic [RowCountWidth-1:0] row_count;
  logic                     rows_done;
  logic                     enter_done;

  // diff is shifted down one row per add, so the row being counted is
  // always diff[ImageWidth-1:0]. This avoids a wide variable-index mux.
  row_popcount #(
    .Width(ImageWidth)
  ) u_row_popcount (
    .bits (diff[ImageWidth-1:0]),
    .count(row_count)
  );

  // All rows have been added once row_idx reaches ImageHeight. The extra
  // ACCUM cycle spent on this check also gives the register timing for
  // fitness/best.
  assign rows_done  = (row_idx == RowIdxWidth'(ImageHeight));
  assign enter_done = (state == ST_ACCUM) && rows_done;
  assign busy       = (state != ST_IDLE);

  // Evaluation FSM and accumulator datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      diff    <= '0;
      row_idx <= '0;
      acc     <= '0;
      id_reg  <= '0;
      done    <= 1'b0;
      fitness <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ACCUM;
            diff    <= image ^ target;
            id_reg  <= id;
            row_idx <= '0;
            acc     <= '0;
          end
        end
        ST_ACCUM: begin
          if (rows_done) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            fitness <= acc;
          end else begin
            acc     <= acc + FitnessWidth'(row_count);
            diff    <= diff >> ImageWidth;
            row_idx <= row_idx + RowIdxWidth'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Best-so-far tracker. A clear on the completing edge wipes the old
  // record first, so the completing result always takes over. Otherwise
  // only a strictly lower count replaces the record, which keeps the
  // earlier id on ties.
  always_ff @(posedge clk) begin
    if (!rst) begin
      best_valid   <= 1'b0;
      best_fitness <= '1;
      best_id      <= '0;
    end else if (enter_done && (clear_best || !best_valid || (acc < best_fitness))) begin
      best_valid   <= 1'b1;
      best_fitness <= acc;
      best_id      <= id_reg;
    end else if (clear_best) begin
      best_valid   <= 1'b0;
      best_fitness <= '1;
    end
  end

endmodule
